// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: raw level in, debounced level
// and pulse outputs back.
interface button_debouncer_if;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic repeating;

  modport master (
    output btn_in,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  repeating
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output repeating
  );
endinterface

// File: rtl/button_debouncer.sv
// Debounces a synchronized button level and emits press/release
// pulses, with optional auto-repeat while the button is held.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 50000,
  parameter int REPEAT_PERIOD   = 20000
) (
  input logic               clk,
  input logic               rst,
  button_debouncer_if.slave bus
);
  localparam int RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RW = $clog2(RMAX) + 1;
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REPEAT
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [DW-1:0] r_db_cnt;
  logic [DW-1:0] w_db_cnt_nx;
  logic [RW-1:0] r_rp_cnt;
  logic [RW-1:0] w_rp_cnt_nx;
  logic          r_level;
  logic          w_level_nx;
  logic          r_press;
  logic          w_press_nx;
  logic          r_release;
  logic          w_release_nx;
  logic          r_repeating;
  logic          w_repeating_nx;
  logic          w_mismatch;
  logic          w_accept;
  logic          w_press_acc;
  logic          w_rel_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_db_cnt    <= '0;
      r_rp_cnt    <= '0;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_repeating <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_db_cnt    <= w_db_cnt_nx;
      r_rp_cnt    <= w_rp_cnt_nx;
      r_level     <= w_level_nx;
      r_press     <= w_press_nx;
      r_release   <= w_release_nx;
      r_repeating <= w_repeating_nx;
    end
  end

  always_comb begin
    w_mismatch   = bus.btn_in != r_level;
    w_accept     = w_mismatch && (r_db_cnt == DB_LAST);
    w_press_acc  = w_accept && bus.btn_in;
    w_rel_acc    = w_accept && !bus.btn_in;
    w_level_nx   = w_accept ? bus.btn_in : r_level;
    w_db_cnt_nx  = '0;
    if (w_mismatch && !w_accept)
      w_db_cnt_nx = r_db_cnt + DW'(1);
    w_state_nx   = r_state;
    w_rp_cnt_nx  = r_rp_cnt;
    w_press_nx   = 1'b0;
    w_release_nx = 1'b0;
    // Release acceptance is checked first so it beats a due repeat.
    unique case (r_state)
      IDLE: begin
        if (w_press_acc) begin
          w_state_nx  = HELD;
          w_rp_cnt_nx = '0;
          w_press_nx  = 1'b1;
        end
      end
      HELD: begin
        if (w_rel_acc) begin
          w_state_nx   = IDLE;
          w_rp_cnt_nx  = '0;
          w_release_nx = 1'b1;
        end else if (REPEAT_EN != 0 && r_rp_cnt == DLY_LAST) begin
          w_state_nx  = REPEAT;
          w_rp_cnt_nx = '0;
          w_press_nx  = 1'b1;
        end else if (r_rp_cnt != DLY_LAST) begin
          w_rp_cnt_nx = r_rp_cnt + RW'(1);
        end
      end
      REPEAT: begin
        if (w_rel_acc) begin
          w_state_nx   = IDLE;
          w_rp_cnt_nx  = '0;
          w_release_nx = 1'b1;
        end else if (r_rp_cnt == PER_LAST) begin
          w_rp_cnt_nx = '0;
          w_press_nx  = 1'b1;
        end else begin
          w_rp_cnt_nx = r_rp_cnt + RW'(1);
        end
      end
      default: begin
        w_state_nx  = IDLE;
        w_rp_cnt_nx = '0;
      end
    endcase
    w_repeating_nx = (w_state_nx == REPEAT);
  end

  assign bus.btn_level     = r_level;
  assign bus.press_pulse   = r_press;
  assign bus.release_pulse = r_release;
  assign bus.repeating     = r_repeating;
endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed timing scenarios plus a
// randomized run against a timestamp-based reference model.
module tb_button_debouncer;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bi  = 1'b0;
  int   checks = 0;
  int   passes = 0;

  button_debouncer_if bus0();
  button_debouncer_if bus1();
  assign bus0.btn_in = bi;
  assign bus1.btn_in = bi;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_EN(1),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_EN(0),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  always #5 clk = ~clk;

  logic [3:0] obs0;
  logic [3:0] obs1;
  assign obs0 = {bus0.btn_level, bus0.press_pulse,
                 bus0.release_pulse, bus0.repeating};
  assign obs1 = {bus1.btn_level, bus1.press_pulse,
                 bus1.release_pulse, bus1.repeating};

  // Model: accept when the input has disagreed with the level for
  // DB edges since the last agreeing edge; repeats by elapsed time.
  int n = 0;
  int t_last[2];
  int p_t[2];
  bit lvl[2];
  bit m_press[2];
  bit m_rel[2];
  bit m_rep[2];
  int k_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        lvl[d] = 0; t_last[d] = n;
        m_press[d] = 0; m_rel[d] = 0; m_rep[d] = 0;
      end
    end else begin
      n++;
      for (int d = 0; d < 2; d++) begin
        m_press[d] = 0;
        m_rel[d] = 0;
        if (bi == lvl[d]) begin
          t_last[d] = n;
        end else if (n - t_last[d] == DB) begin
          lvl[d] = bi;
          t_last[d] = n;
          if (bi) begin
            m_press[d] = 1;
            p_t[d] = n;
          end else begin
            m_rel[d] = 1;
          end
        end
        k_m = n - p_t[d];
        if (d == 0 && lvl[d] && !m_press[d] && k_m >= RD
            && (k_m - RD) % RP == 0)
          m_press[d] = 1;
        m_rep[d] = (d == 0) && lvl[d] && (k_m >= RD);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bi = 1'b0;
    repeat (DB + 4) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bi = 1'($urandom_range(0, 1));
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs0 !== 4'b0000) $display("FAIL reset_dut0: got %b want 0000", obs0);
      else passes++;
      checks++;
      if (obs1 !== 4'b0000) $display("FAIL reset_dut1: got %b want 0000", obs1);
      else passes++;
    end
    bi = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    logic [3:0] want;
    go_idle();
    bi = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      want = (i < 3) ? 4'b0000 : (i == 3) ? 4'b1100 : 4'b1000;
      checks++;
      if (obs0 !== want)
        $display("FAIL clean_press edge E+%0d: got %b want %b", i, obs0, want);
      else passes++;
      checks++;
      if (obs1 !== want)
        $display("FAIL clean_press_norep edge E+%0d: got %b want %b", i, obs1, want);
      else passes++;
    end
  endtask

  task automatic test_bounce();
    int pat[8] = '{1, 1, 1, 0, 1, 1, 1, 1};
    int cnt = 0;
    go_idle();
    for (int i = 0; i < 8; i++) begin
      bi = pat[i][0];
      step();
      if (bus0.press_pulse) cnt++;
      checks++;
      if (bus0.btn_level !== (i == 7))
        $display("FAIL bounce_level edge %0d: got %b want %b", i, bus0.btn_level, (i == 7));
      else passes++;
    end
    repeat (3) begin
      step();
      if (bus0.press_pulse) cnt++;
    end
    checks++;
    if (cnt !== 1) $display("FAIL bounce_press_count: got %0d want 1", cnt);
    else passes++;
  endtask

  task automatic find_press(input string name);
    bit seen = 0;
    for (int i = 0; i < DB + 2 && !seen; i++) begin
      step();
      seen = bus0.press_pulse;
    end
    checks++;
    if (!seen) $display("FAIL %s_no_press: got none want press_pulse", name);
    else passes++;
  endtask

  task automatic test_repeat();
    bit wp;
    go_idle();
    bi = 1'b1;
    find_press("repeat");
    for (int off = 1; off <= 30; off++) begin
      step();
      wp = (off >= RD) && ((off - RD) % RP == 0);
      checks++;
      if (bus0.press_pulse !== wp)
        $display("FAIL repeat_press P+%0d: got %b want %b", off, bus0.press_pulse, wp);
      else passes++;
      checks++;
      if (bus0.repeating !== (off >= RD))
        $display("FAIL repeat_flag P+%0d: got %b want %b", off, bus0.repeating, (off >= RD));
      else passes++;
      checks++;
      if (obs1 !== 4'b1000)
        $display("FAIL repeat_norep P+%0d: got %b want 1000", off, obs1);
      else passes++;
    end
  endtask

  task automatic test_release_collision();
    go_idle();
    bi = 1'b1;
    find_press("collide");
    repeat (16) step();
    bi = 1'b0;
    repeat (3) step();
    checks++;
    if (obs0 !== 4'b1001) $display("FAIL collide_pre P+19: got %b want 1001", obs0);
    else passes++;
    step();
    checks++;
    if (obs0 !== 4'b0010) $display("FAIL collide P+20: got %b want 0010", obs0);
    else passes++;
    checks++;
    if (obs1 !== 4'b0010) $display("FAIL collide_norep P+20: got %b want 0010", obs1);
    else passes++;
    step();
    checks++;
    if (obs0 !== 4'b0000) $display("FAIL collide_after P+21: got %b want 0000", obs0);
    else passes++;
  endtask

  task automatic test_norepeat();
    int np1 = 0;
    int nr1 = 0;
    int nrep1 = 0;
    int np0 = 0;
    go_idle();
    bi = 1'b1;
    for (int i = 0; i < DB + 50 + DB + 4; i++) begin
      if (i == DB + 50) bi = 1'b0;
      step();
      np1 += int'(bus1.press_pulse);
      nr1 += int'(bus1.release_pulse);
      nrep1 += int'(bus1.repeating);
      np0 += int'(bus0.press_pulse);
    end
    checks++;
    if (np1 !== 1) $display("FAIL norep_press: got %0d want 1", np1);
    else passes++;
    checks++;
    if (nr1 !== 1) $display("FAIL norep_release: got %0d want 1", nr1);
    else passes++;
    checks++;
    if (nrep1 !== 0) $display("FAIL norep_repeating: got %0d want 0", nrep1);
    else passes++;
    checks++;
    if (np0 !== 10) $display("FAIL rep_press_count: got %0d want 10", np0);
    else passes++;
  endtask

  task automatic test_reset_mid();
    logic [3:0] want;
    go_idle();
    bi = 1'b1;
    find_press("rstmid");
    repeat (12) step();
    rst = 1'b1;
    #1;
    checks++;
    if (obs0 !== 4'b0000) $display("FAIL rstmid_async: got %b want 0000", obs0);
    else passes++;
    checks++;
    if (obs1 !== 4'b0000) $display("FAIL rstmid_async_norep: got %b want 0000", obs1);
    else passes++;
    step();
    step();
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      want = (i == 4) ? 4'b1100 : 4'b0000;
      checks++;
      if (obs0 !== want)
        $display("FAIL rstmid_repress edge %0d: got %b want %b", i, obs0, want);
      else passes++;
    end
  endtask

  task automatic test_random();
    logic [3:0] e0;
    logic [3:0] e1;
    int run;
    int c = 0;
    while (c < 800) begin
      bi = 1'($urandom_range(0, 1));
      run = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45))
                                        : int'($urandom_range(1, 6));
      for (int j = 0; j < run; j++) begin
        step();
        e0 = {lvl[0], m_press[0], m_rel[0], m_rep[0]};
        e1 = {lvl[1], m_press[1], m_rel[1], m_rep[1]};
        checks++;
        if (obs0 !== e0) $display("FAIL random_dut0 cyc %0d: got %b want %b", c, obs0, e0);
        else passes++;
        checks++;
        if (obs1 !== e1) $display("FAIL random_dut1 cyc %0d: got %b want %b", c, obs1, e1);
        else passes++;
        checks++;
        if ((bus0.press_pulse & bus0.release_pulse) !== 1'b0)
          $display("FAIL random_both_pulses cyc %0d: got 1 want 0", c);
        else passes++;
        c++;
      end
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        #1;
        checks++;
        if (obs0 !== 4'b0000) $display("FAIL random_rst cyc %0d: got %b want 0000", c, obs0);
        else passes++;
        step();
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_release_collision();
    test_norepeat();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500, is the number of consecutive mismatching samples needed to accept a level change (5 ms at 100 kHz).
REQ-002 Parameter REPEAT_EN, default 1, enables auto-repeat when 1 and disables it when 0.
REQ-003 Parameter REPEAT_DELAY, default 50000, is the number of cycles from the accepted press to the first repeat pulse (500 ms).
REQ-004 Parameter REPEAT_PERIOD, default 20000, is the number of cycles between subsequent repeat pulses (200 ms).
REQ-005 clk  input  1  system clock, 100 kHz nominal; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 btn_in  input  1  button level, already passed through the 2-stage synchronizer; active-high.
REQ-008 btn_level  output  1  debounced button level.
REQ-009 press_pulse  output  1  one-cycle pulse on an accepted press and on each auto-repeat; drives the pwm increase/decrease input.
REQ-010 release_pulse  output  1  one-cycle pulse on an accepted release.
REQ-011 repeating  output  1  high while the block is in state REPEAT.

Function
REQ-012 All outputs SHALL be registered, and no output SHALL depend combinationally on btn_in.
REQ-013 The mismatch counter SHALL increment on each edge where btn_in != btn_level.
REQ-014 The mismatch counter SHALL clear to 0 on any edge where btn_in == btn_level, so a single-cycle bounce restarts the count.
REQ-015 On the edge where btn_in != btn_level and the mismatch count equals DEBOUNCE_CYCLES-1, btn_level SHALL take btn_in and the mismatch counter SHALL clear.
REQ-016 Acceptance latency SHALL be exactly DEBOUNCE_CYCLES edges after btn_in changes and then holds stable.
REQ-017 press_pulse SHALL be high for exactly the one cycle following a 0->1 acceptance.
REQ-018 release_pulse SHALL be high for exactly the one cycle following a 1->0 acceptance.
REQ-019 The FSM SHALL have three states: IDLE (btn_level=0), HELD (pressed, waiting out REPEAT_DELAY) and REPEAT (pressed, emitting periodic pulses).
REQ-020 Transition IDLE->HELD SHALL occur on press acceptance and SHALL clear the repeat counter.
REQ-021 HELD->REPEAT SHALL occur when the repeat counter reaches REPEAT_DELAY-1, provided REPEAT_EN=1; press_pulse SHALL fire on that edge and the repeat counter SHALL clear.
REQ-022 In REPEAT, press_pulse SHALL fire and the repeat counter SHALL clear each time the counter reaches REPEAT_PERIOD-1.
REQ-023 With REPEAT_EN=0, the block SHALL remain in HELD until release and SHALL emit no repeat pulses.
REQ-024 HELD or REPEAT SHALL return to IDLE on release acceptance, clearing the repeat counter.
REQ-025 If release acceptance and a repeat pulse fall on the same edge, the release SHALL win: release_pulse fires and press_pulse does not.
REQ-026 press_pulse and release_pulse SHALL never be high in the same cycle.
REQ-027 Bounces while pressed SHALL only affect the mismatch counter; the repeat counter and FSM state SHALL be unaffected until release is accepted.
REQ-028 Counter widths SHALL be $clog2 of the largest count they hold, plus 1, and counters SHALL never wrap.
REQ-029 DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD SHALL each be >= 2; smaller values are unsupported.

Reset
REQ-030 While rst=1, btn_level, press_pulse, release_pulse and repeating SHALL be 0, both counters SHALL be 0, and the state SHALL be IDLE, regardless of clk.
REQ-031 Asserting rst mid-debounce or mid-repeat SHALL abort immediately, with no pulse emitted.
REQ-032 If btn_in is 1 when rst deasserts, the press SHALL be accepted normally after DEBOUNCE_CYCLES edges and SHALL emit press_pulse.

Verification
Parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, REPEAT_EN=1 unless stated.
REQ-033 Clean press: btn_in 0->1 sampled first at edge E -> btn_level=1 and press_pulse=1 after edge E+3 for one cycle only.
REQ-034 Bounce: btn_in pattern 1,1,1,0,1,1,1,1 -> no acceptance until the 4th consecutive 1, i.e. 8 edges after start, and exactly one press_pulse.
REQ-035 Hold for 30 cycles after acceptance at edge P -> press_pulse at P, P+10, P+15, P+20, P+25, P+30; repeating=1 from P+10.
REQ-036 Release timed so its acceptance lands on edge P+20 -> release_pulse=1 and no press_pulse at P+20; state IDLE and repeating=0.
REQ-037 REPEAT_EN=0, hold for 50 cycles -> exactly one press_pulse and one release_pulse; repeating never 1.
REQ-038 rst pulsed at P+12 while held -> all outputs 0 immediately; with btn_in still 1, a new press_pulse occurs 4 edges after rst deasserts.
